// File: rtl/turn_referee_pkg.sv
// Shared constants, FSM encoding and board arithmetic helper for the turn referee.
package turn_referee_pkg;

  localparam int unsigned BOARD_LEN   = 24;
  localparam int unsigned TILE_W      = 4;
  localparam int unsigned POS_W       = 5;
  localparam int unsigned MAX_PLAYERS = 3;
  localparam int unsigned TILE_PERIOD = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_STEP  = 2'd2,
    ST_NEXT  = 2'd3
  } state_e;

  // Square reached by moving d squares forward from p on a ring of len squares.
  function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] p,
                                                input logic [1:0]       d,
                                                input int unsigned      len);
    logic [POS_W:0] s;
    s = {1'b0, p} + (POS_W+1)'(d);
    if (s >= (POS_W+1)'(len)) s = s - (POS_W+1)'(len);
    return s[POS_W-1:0];
  endfunction

endpackage

// File: rtl/turn_referee_if.sv
// Handshake bundle between the game controller (master) and the turn referee (slave).
interface turn_referee_if #(
  parameter int unsigned TILE_W = turn_referee_pkg::TILE_W
);

  logic [1:0]                           N;
  logic [turn_referee_pkg::POS_W-1:0]   pos1;
  logic [turn_referee_pkg::POS_W-1:0]   pos2;
  logic [turn_referee_pkg::POS_W-1:0]   pos3;
  logic                                 flip_vld;
  logic [TILE_W-1:0]                    flip_card;
  logic                                 p_da1;
  logic                                 p_da2;
  logic                                 p_da3;
  logic [1:0]                           cur_player;
  logic                                 busy;
  logic                                 turn_end;

  modport master (
    output N, pos1, pos2, pos3, flip_vld, flip_card,
    input  p_da1, p_da2, p_da3, cur_player, busy, turn_end
  );

  modport slave (
    input  N, pos1, pos2, pos3, flip_vld, flip_card,
    output p_da1, p_da2, p_da3, cur_player, busy, turn_end
  );

endinterface

// File: rtl/turn_referee_board_tile_rom.sv
// Board picture table: square i shows picture i mod 12.
module board_tile_rom
  import turn_referee_pkg::*;
#(
  parameter int unsigned TILE_W = turn_referee_pkg::TILE_W
) (
  input  logic [POS_W-1:0]  idx_i,
  output logic [TILE_W-1:0] tile_o
);

  assign tile_o = TILE_W'(idx_i % POS_W'(TILE_PERIOD));

endmodule

// File: rtl/turn_referee.sv
// Turn referee: checks a flipped card against the next free square and moves or passes the turn.
// Define REFEREE_JUMP_EN to skip squares occupied by other active players.
module turn_referee #(
  parameter int unsigned BOARD_LEN = turn_referee_pkg::BOARD_LEN,
  parameter int unsigned TILE_W    = turn_referee_pkg::TILE_W
) (
  input  logic          B,
  input  logic          rst,
  turn_referee_if.slave bus
);
  import turn_referee_pkg::*;

  state_e                   state_q, state_d;
  logic [TILE_W-1:0]        card_q, card_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [1:0]               cur_q, cur_d;
  logic [MAX_PLAYERS-1:0]   p_da_q, p_da_d;
  logic                     busy_q, busy_d;
  logic                     turn_end_q, turn_end_d;

  logic [1:0]               active_c;
  logic [POS_W-1:0]         pos_c [MAX_PLAYERS];
  logic [POS_W-1:0]         cur_pos_c;
  logic [POS_W-1:0]         target_c;
  logic [1:0]               steps_c;
  logic [TILE_W-1:0]        tile_c;

  // N=3 is treated as a three-player game.
  always_comb begin
    active_c = (bus.N == 2'd3) ? 2'd3 : bus.N + 2'd1;
    pos_c[0] = bus.pos1;
    pos_c[1] = bus.pos2;
    pos_c[2] = bus.pos3;
    case (cur_q)
      2'd1:    cur_pos_c = bus.pos2;
      2'd2:    cur_pos_c = bus.pos3;
      default: cur_pos_c = bus.pos1;
    endcase
  end

  // Target square: scanned from farthest to nearest so the nearest free square wins.
  always_comb begin
`ifdef REFEREE_JUMP_EN
    logic [POS_W-1:0] cand;
    logic             occ;
    cand = '0;
    occ  = 1'b0;
`endif
    target_c = wrap_inc(cur_pos_c, 2'd1, BOARD_LEN);
    steps_c  = 2'd1;
`ifdef REFEREE_JUMP_EN
    for (int d = 3; d >= 1; d--) begin
      cand = wrap_inc(cur_pos_c, 2'(d), BOARD_LEN);
      occ  = 1'b0;
      for (int j = 0; j < int'(MAX_PLAYERS); j++) begin
        if ((2'(j) != cur_q) && (2'(j) < active_c) && (pos_c[j] == cand)) occ = 1'b1;
      end
      if (!occ) begin
        target_c = cand;
        steps_c  = 2'(d);
      end
    end
`endif
  end

  board_tile_rom #(
    .TILE_W (TILE_W)
  ) u_tile_rom (
    .idx_i  (target_c),
    .tile_o (tile_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    card_d     = card_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    p_da_d     = '0;
    turn_end_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.flip_vld) begin
          card_d  = bus.flip_card;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (tile_c == card_q) begin
          cnt_d   = steps_c;
          state_d = ST_STEP;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_STEP: begin
        if (cur_q < active_c) p_da_d = MAX_PLAYERS'(1) << cur_q;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = ST_IDLE;
      end
      ST_NEXT: begin
        turn_end_d = 1'b1;
        cur_d      = ((cur_q + 2'd1) >= active_c) ? 2'd0 : cur_q + 2'd1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge B or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      card_q     <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      p_da_q     <= '0;
      busy_q     <= 1'b0;
      turn_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      card_q     <= card_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      p_da_q     <= p_da_d;
      busy_q     <= busy_d;
      turn_end_q <= turn_end_d;
    end
  end

  assign bus.p_da1      = p_da_q[0];
  assign bus.p_da2      = p_da_q[1];
  assign bus.p_da3      = p_da_q[2];
  assign bus.cur_player = cur_q;
  assign bus.busy       = busy_q;
  assign bus.turn_end   = turn_end_q;

endmodule
